// File: rtl/imem_block_server_pkg.sv
// ----------------------------------------------------------------------------
// imem_pkg
// Shared types and constants for the instruction main-memory model and the
// latency counter it uses (also intended for the data-memory model).
//   state_t       : block-server FSM state (IDLE / BUSY / RESP)
//   BLOCK_BYTES   : bytes per cache block
//   BLOCK_ADDR_W  : width of the block address from the cache ({tag, index})
//   BYTE_ADDR_W   : width of a byte address into the array
//   CNT_W         : width of the access-latency down-counter
//   byte_addr()   : byte address of byte 'off' inside block 'blk'
// ----------------------------------------------------------------------------
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned BLOCK_BYTES  = 16;
    localparam int unsigned BLOCK_OFF_W  = 4;
    localparam int unsigned BLOCK_ADDR_W = 6;
    localparam int unsigned BYTE_ADDR_W  = 10;
    localparam int unsigned CNT_W        = 8;

    function automatic logic [BYTE_ADDR_W-1:0] byte_addr(
        input logic [BLOCK_ADDR_W-1:0] blk,
        input logic [BLOCK_OFF_W-1:0]  off
    );
        return {blk, off};
    endfunction

endpackage

// File: rtl/imem_block_server_if.sv
// ----------------------------------------------------------------------------
// imem_block_server_if
// Refill bus between the instruction cache (master) and the instruction
// main-memory model (slave).
//   READ     : block read request, held by the cache until BUSYWAIT is low
//   ADDRESS  : block address {tag, index}
//   READDATA : 128-bit block, byte i on bits [8i+7:8i]
//   BUSYWAIT : request pending or in service
// ----------------------------------------------------------------------------
interface imem_block_server_if;
    import imem_pkg::*;

    logic                    READ;
    logic [BLOCK_ADDR_W-1:0] ADDRESS;
    logic [127:0]            READDATA;
    logic                    BUSYWAIT;

    modport master (
        output READ,
        output ADDRESS,
        input  READDATA,
        input  BUSYWAIT
    );

    modport slave (
        input  READ,
        input  ADDRESS,
        output READDATA,
        output BUSYWAIT
    );

endinterface

// File: rtl/imem_latency_counter.sv
// ----------------------------------------------------------------------------
// imem_latency_counter
// Loadable down-counter that models backing-store access latency. Saturates
// at zero instead of wrapping.
//   CLK      : clock, rising edge
//   RESET    : synchronous, active-high; clears the count
//   load     : load load_val (takes priority over en)
//   load_val : start value
//   en       : decrement when nonzero
//   zero     : count is zero
// ----------------------------------------------------------------------------
module imem_latency_counter
    import imem_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign zero = (r_cnt == '0);

endmodule

// File: rtl/imem_block_server.sv
// ----------------------------------------------------------------------------
// imem_block_server
// Instruction main-memory model serving 16-byte blocks to the instruction
// cache on a miss, after LATENCY cycles in BUSY. A byte-wide load port writes
// the program image; the array has no reset so the image survives RESET.
//   LATENCY   : BUSY cycles per block read (1..255)
//   BLOCKS    : number of 16-byte blocks
//   CLK       : clock, rising edge
//   RESET     : synchronous, active-high; aborts an access in flight
//   mem_if    : refill bus (slave side): READ, ADDRESS, READDATA, BUSYWAIT
//   LOAD_EN   : program-load byte write enable (any state)
//   LOAD_ADDR : byte address of the load
//   LOAD_DATA : byte to write
// ----------------------------------------------------------------------------
module imem_block_server
    import imem_pkg::*;
#(
    parameter int unsigned LATENCY = 40,
    parameter int unsigned BLOCKS  = 64
) (
    input  logic                   CLK,
    input  logic                   RESET,
    imem_block_server_if.slave     mem_if,
    input  logic                   LOAD_EN,
    input  logic [BYTE_ADDR_W-1:0] LOAD_ADDR,
    input  logic [7:0]             LOAD_DATA
);

    localparam int unsigned      MEM_BYTES = BLOCKS * BLOCK_BYTES;
    localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(LATENCY - 1);

    state_t                  r_state;
    state_t                  w_next;
    logic [BLOCK_ADDR_W-1:0] r_addr_q;
    logic [127:0]            r_readdata;
    logic [7:0]              r_mem [0:MEM_BYTES-1];

    logic                    w_accept;
    logic                    w_capture;
    logic                    w_busy;
    logic                    w_cnt_zero;
    logic [127:0]            w_block;

    // BUSY lasts LATENCY edges: loaded with LATENCY-1, capture on the edge
    // where the count is already zero.
    imem_latency_counter u_cnt (
        .CLK      (CLK),
        .RESET    (RESET),
        .load     (w_accept),
        .load_val (CNT_INIT),
        .en       (r_state == BUSY),
        .zero     (w_cnt_zero)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (mem_if.READ) w_next = BUSY;
            BUSY:    if (w_cnt_zero)  w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_accept  = (r_state == IDLE) && mem_if.READ;
        w_capture = (r_state == BUSY) && w_cnt_zero;
        w_busy    = !RESET && (w_accept || (r_state == BUSY));
    end

    assign mem_if.BUSYWAIT = w_busy;
    assign mem_if.READDATA = r_readdata;

    // Address is latched at acceptance so later ADDRESS changes are ignored.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_addr_q <= '0;
        end else if (w_accept) begin
            r_addr_q <= mem_if.ADDRESS;
        end
    end

    // Gather the 16 bytes of the latched block.
    always_comb begin
        w_block = '0;
        for (int unsigned k = 0; k < BLOCK_BYTES; k++) begin
            w_block[8*k +: 8] = r_mem[byte_addr(r_addr_q, BLOCK_OFF_W'(k))];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_readdata <= '0;
        end else if (w_capture) begin
            r_readdata <= w_block;
        end
    end

    // Program-load port; a same-edge capture sees the pre-write byte since
    // both sample the array before the update.
    always_ff @(posedge CLK) begin
        if (LOAD_EN) begin
            r_mem[LOAD_ADDR] <= LOAD_DATA;
        end
    end

endmodule
